// File: rtl/dual_port_bram_pkg.sv
// Shared types and helpers for the dual-port block RAM.
// Holds the cycle-counter width and the debug scan-window test.
package dual_port_bram_pkg;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when debug printing is wanted for this cycle count.
    function automatic logic scan_active(
        input logic en,
        input cnt_t cnt,
        input cnt_t lo,
        input cnt_t hi
    );
        return en && (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/dual_port_bram.sv
// True dual-port block RAM, one clock, registered read-first reads.
// Ports: clock, reset (sync, active-low; clears only the cycle counter),
//   per port x in {1,2}: readEnable_x, writeEnable_x, address_x,
//   writeData_x in, readData_x out; scan enables simulation-only tracing.
module dual_port_bram
    import dual_port_bram_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  readEnable_1,
    input  logic                  writeEnable_1,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] writeData_1,
    output logic [DATA_WIDTH-1:0] readData_1,
    input  logic                  readEnable_2,
    input  logic                  writeEnable_2,
    input  logic [ADDR_WIDTH-1:0] address_2,
    input  logic [DATA_WIDTH-1:0] writeData_2,
    output logic [DATA_WIDTH-1:0] readData_2,
    input  logic                  scan
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] rdata1_q = '0;
    logic [DATA_WIDTH-1:0] rdata2_q = '0;
    logic [DATA_WIDTH-1:0] rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_d;

    cnt_t cycle_q = '0;
    cnt_t cycle_d;

    // Reads sample the array before this edge's writes land (read-first).
    always_comb begin
        rdata1_d = '0;
        rdata2_d = '0;
        if (readEnable_1) rdata1_d = mem_q[address_1];
        if (readEnable_2) rdata2_d = mem_q[address_2];
    end

    always_comb begin
        cycle_d = '0;
        if (reset) cycle_d = cycle_q + 1'b1;
    end

    // Port 2's write comes last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (writeEnable_1) mem_q[address_1] <= writeData_1;
        if (writeEnable_2) mem_q[address_2] <= writeData_2;
    end

    // Read data and memory ignore reset; only the counter is cleared.
    always_ff @(posedge clock) begin
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
        cycle_q  <= cycle_d;
    end

    assign readData_1 = rdata1_q;
    assign readData_2 = rdata2_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (scan_active(scan, cycle_q,
                        cnt_t'(SCAN_CYCLES_MIN),
                        cnt_t'(SCAN_CYCLES_MAX))) begin
            $display("core %0d cyc %0d | p1 re=%0b we=%0b a=%0h wd=%0h rd=%0h | p2 re=%0b we=%0b a=%0h wd=%0h rd=%0h",
                     CORE, cycle_q,
                     readEnable_1, writeEnable_1, address_1,
                     writeData_1, readData_1,
                     readEnable_2, writeEnable_2, address_2,
                     writeData_2, readData_2);
        end
    end
`endif

endmodule

// File: tb/tb_dual_port_bram.sv
// Scoreboard bench for dual_port_bram.
// Expected read data comes from a bench-side memory model.
module tb_dual_port_bram;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          re1, we1, re2, we2;
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] wd1, wd2;
    logic [DW-1:0] rd1, rd2;
    logic          scan;

    int assertions = 0;
    int failures   = 0;

    logic [DW-1:0] model [1<<AW];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];

    always #5 clock = ~clock;

    dual_port_bram #(
        .CORE(0), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .SCAN_CYCLES_MIN(2), .SCAN_CYCLES_MAX(4)
    ) dut (
        .clock(clock), .reset(reset),
        .readEnable_1(re1), .writeEnable_1(we1),
        .address_1(a1), .writeData_1(wd1), .readData_1(rd1),
        .readEnable_2(re2), .writeEnable_2(we2),
        .address_2(a2), .writeData_2(wd2), .readData_2(rd2),
        .scan(scan)
    );

    // Drive one cycle, push model expectations, advance past the edge.
    task automatic step(
        input logic r1, input logic w1,
        input logic [AW-1:0] ad1, input logic [DW-1:0] d1,
        input logic r2, input logic w2,
        input logic [AW-1:0] ad2, input logic [DW-1:0] d2
    );
        re1 = r1; we1 = w1; a1 = ad1; wd1 = d1;
        re2 = r2; we2 = w2; a2 = ad2; wd2 = d2;
        q1.push_back(r1 ? model[ad1] : '0);
        q2.push_back(r2 ? model[ad2] : '0);
        if (w1) model[ad1] = d1;
        if (w2) model[ad2] = d2;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        if (rd1 !== '0 || rd2 !== '0) begin
            failures++;
            $display("FAIL time0_rd: rd1=%h rd2=%h required 0", rd1, rd2);
        end
        assertions++;
        reset = 1'b0;
        idle();
        idle();
        if (dut.cycle_q !== 32'd0) begin
            failures++;
            $display("FAIL cnt_reset: got %0d required 0", dut.cycle_q);
        end
        assertions++;
        reset = 1'b1;
        idle();
        idle();
        idle();
        if (dut.cycle_q !== 32'd3) begin
            failures++;
            $display("FAIL cnt_run: got %0d required 3", dut.cycle_q);
        end
        assertions++;
        while (q1.size() > 0) begin
            e = q1.pop_front();
            void'(q2.pop_front());
            if (e !== 32'd0) begin
                failures++;
                $display("FAIL sb_reset: model=%h required 0", e);
            end
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] e1, e2;
        step(0, 1, 8'd0, 32'd10, 0, 1, 8'd1, 32'd11);
        e1 = q1.pop_front(); e2 = q2.pop_front();
        if (rd1 !== e1 || rd2 !== e2 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
            failures++;
            $display("FAIL basic_wr: rd1=%h rd2=%h required 0 0", rd1, rd2);
        end
        assertions++;
        step(1, 0, 8'd0, '0, 1, 0, 8'd1, '0);
        e1 = q1.pop_front(); e2 = q2.pop_front();
        if (rd1 !== e1 || rd1 !== 32'd10) begin
            failures++;
            $display("FAIL basic_rd1: got %h required %h", rd1, e1);
        end
        assertions++;
        if (rd2 !== e2 || rd2 !== 32'd11) begin
            failures++;
            $display("FAIL basic_rd2: got %h required %h", rd2, e2);
        end
        assertions++;
    endtask

    task automatic test_collision();
        logic [DW-1:0] e1, e2;
        step(0, 1, 8'd5, 32'hAA, 0, 1, 8'd5, 32'hBB);
        void'(q1.pop_front()); void'(q2.pop_front());
        step(1, 0, 8'd5, '0, 1, 0, 8'd5, '0);
        e1 = q1.pop_front(); e2 = q2.pop_front();
        if (rd1 !== 32'hBB || rd1 !== e1) begin
            failures++;
            $display("FAIL coll_rd1: got %h required BB", rd1);
        end
        assertions++;
        if (rd2 !== 32'hBB || rd2 !== e2) begin
            failures++;
            $display("FAIL coll_rd2: got %h required BB", rd2);
        end
        assertions++;
    endtask

    task automatic test_read_first();
        logic [DW-1:0] e2;
        step(0, 1, 8'd3, 32'h22, 0, 0, '0, '0);
        void'(q1.pop_front()); void'(q2.pop_front());
        step(0, 1, 8'd3, 32'h55, 1, 0, 8'd3, '0);
        void'(q1.pop_front()); e2 = q2.pop_front();
        if (rd2 !== 32'h22 || rd2 !== e2) begin
            failures++;
            $display("FAIL rf_old: got %h required 22", rd2);
        end
        assertions++;
        step(0, 0, '0, '0, 1, 0, 8'd3, '0);
        void'(q1.pop_front()); e2 = q2.pop_front();
        if (rd2 !== 32'h55 || rd2 !== e2) begin
            failures++;
            $display("FAIL rf_new: got %h required 55", rd2);
        end
        assertions++;
        // Same-port read and write returns the old word.
        step(1, 1, 8'd3, 32'h77, 0, 0, '0, '0);
        void'(q2.pop_front());
        if (rd1 !== 32'h55 || rd1 !== q1.pop_front()) begin
            failures++;
            $display("FAIL rw_same: got %h required 55", rd1);
        end
        assertions++;
    endtask

    task automatic test_read_disable();
        logic [DW-1:0] e1;
        step(1, 0, 8'd0, '0, 0, 0, '0, '0);
        void'(q2.pop_front());
        e1 = q1.pop_front();
        if (rd1 !== 32'd10 || rd1 !== e1) begin
            failures++;
            $display("FAIL rdis_pre: got %h required 0a", rd1);
        end
        assertions++;
        step(0, 0, 8'd0, '0, 0, 0, '0, '0);
        void'(q2.pop_front());
        e1 = q1.pop_front();
        if (rd1 !== 32'd0 || rd1 !== e1) begin
            failures++;
            $display("FAIL rdis: got %h required 0", rd1);
        end
        assertions++;
    endtask

    task automatic test_reset_indep();
        logic [DW-1:0] e1, e2;
        step(0, 1, 8'd255, 32'h1234, 0, 0, '0, '0);
        void'(q1.pop_front()); void'(q2.pop_front());
        reset = 1'b0;
        idle(); idle(); idle();
        void'(q1.pop_front()); void'(q2.pop_front());
        void'(q1.pop_front()); void'(q2.pop_front());
        void'(q1.pop_front()); void'(q2.pop_front());
        if (dut.cycle_q !== 32'd0) begin
            failures++;
            $display("FAIL cnt_hold: got %0d required 0", dut.cycle_q);
        end
        assertions++;
        reset = 1'b1;
        step(1, 0, 8'd255, '0, 1, 0, 8'd255, '0);
        e1 = q1.pop_front(); e2 = q2.pop_front();
        if (rd1 !== 32'h1234 || rd1 !== e1) begin
            failures++;
            $display("FAIL rst_mem1: got %h required 1234", rd1);
        end
        assertions++;
        if (rd2 !== 32'h1234 || rd2 !== e2) begin
            failures++;
            $display("FAIL rst_mem2: got %h required 1234", rd2);
        end
        assertions++;
    endtask

    task automatic test_random();
        logic [DW-1:0] e1, e2;
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 AW'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 AW'($urandom_range(0, 7)), $urandom);
            e1 = q1.pop_front(); e2 = q2.pop_front();
            if (rd1 !== e1) begin
                failures++;
                $display("FAIL rand_rd1[%0d]: got %h required %h", i, rd1, e1);
            end
            assertions++;
            if (rd2 !== e2) begin
                failures++;
                $display("FAIL rand_rd2[%0d]: got %h required %h", i, rd2, e2);
            end
            assertions++;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
        reset = 1'b0; scan = 1'b1;
        re1 = 0; we1 = 0; a1 = '0; wd1 = '0;
        re2 = 0; we2 = 0; a2 = '0; wd2 = '0;
        #1;
        test_reset();
        scan = 1'b0;
        test_basic();
        test_collision();
        test_read_first();
        test_read_disable();
        test_reset_indep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
